// File: rtl/psram_test_sequencer_if.sv
// Bus between the PSRAM test sequencer and its memory controller / observer.
// The master side is the sequencer. The slave side is the controller plus status sink.
interface psram_test_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [15:0] data_read;
  logic        write_strb;
  logic        read_strb;
  logic [21:0] address;
  logic [15:0] data_write;
  logic [3:0]  step;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [7:0]  err_count;
  logic [21:0] first_fail_addr;

  modport master (
    input  start, mem_ready, data_read,
    output write_strb, read_strb, address, data_write, step,
           done, pass, timeout, err_count, first_fail_addr
  );

  modport slave (
    output start, mem_ready, data_read,
    input  write_strb, read_strb, address, data_write, step,
           done, pass, timeout, err_count, first_fail_addr
  );
endinterface

// File: rtl/psram_test_sequencer.sv
// Write-then-read-back pattern test over NUM_WORDS PSRAM words.
// Every controller handshake wait is bounded by TIMEOUT cycles.
module psram_test_sequencer #(
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [15:0] SEED      = 16'hA5A5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  psram_test_sequencer_if.master bus
);

  localparam int unsigned WaitW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0] LastIdx = 16'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWaitInit = 4'd1,
    StWrIssue  = 4'd2,
    StWrAck    = 4'd3,
    StWrDone   = 4'd4,
    StRdIssue  = 4'd5,
    StRdAck    = 4'd6,
    StRdDone   = 4'd7,
    StCheck    = 4'd8,
    StFinish   = 4'd9,
    StError    = 4'd10
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_idx, w_idx_nxt;
  logic [WaitW-1:0] r_wait, w_wait_nxt, w_wait_inc;
  logic             r_wstrb, w_wstrb_nxt;
  logic             r_rstrb, w_rstrb_nxt;
  logic [15:0]      r_wdata, w_wdata_nxt;
  logic [15:0]      r_rdata, w_rdata_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [7:0]       r_err, w_err_nxt;
  logic [15:0]      r_ffa, w_ffa_nxt;
  logic             w_timed_out;
  logic             w_last;

  function automatic logic [15:0] f_pattern(input logic [15:0] idx);
    f_pattern = {idx[7:0], ~idx[7:0]} ^ SEED;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_wait    <= '0;
      r_wstrb   <= 1'b0;
      r_rstrb   <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= '0;
      r_ffa     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wait    <= w_wait_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_rstrb   <= w_rstrb_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_timeout <= w_timeout_nxt;
      r_err     <= w_err_nxt;
      r_ffa     <= w_ffa_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_timeout_nxt = r_timeout;
    w_err_nxt     = r_err;
    w_ffa_nxt     = r_ffa;
    w_wait_inc    = r_wait + 1'b1;
    w_timed_out   = (w_wait_inc == WaitW'(TIMEOUT));
    w_last        = (r_idx == LastIdx);

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_nxt   = StWaitInit;
          w_idx_nxt     = '0;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_err_nxt     = '0;
          w_ffa_nxt     = '0;
        end
      end
      StWaitInit: begin
        if (bus.mem_ready)    w_state_nxt = StWrIssue;
        else if (w_timed_out) w_state_nxt = StError;
      end
      StWrIssue: w_state_nxt = StWrAck;
      StWrAck: begin
        if (!bus.mem_ready)   w_state_nxt = StWrDone;
        else if (w_timed_out) w_state_nxt = StError;
      end
      StWrDone: begin
        if (bus.mem_ready) begin
          if (w_last) begin
            w_state_nxt = StRdIssue;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = StWrIssue;
            w_idx_nxt   = r_idx + 16'd1;
          end
        end else if (w_timed_out) begin
          w_state_nxt = StError;
        end
      end
      StRdIssue: w_state_nxt = StRdAck;
      StRdAck: begin
        if (!bus.mem_ready)   w_state_nxt = StRdDone;
        else if (w_timed_out) w_state_nxt = StError;
      end
      StRdDone: begin
        if (bus.mem_ready) begin
          w_rdata_nxt = bus.data_read;
          w_state_nxt = StCheck;
        end else if (w_timed_out) begin
          w_state_nxt = StError;
        end
      end
      StCheck: begin
        if (r_rdata != f_pattern(r_idx)) begin
          if (r_err == 8'd0)  w_ffa_nxt = r_idx;
          if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
        end
        if (w_last) begin
          w_state_nxt = StFinish;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 8'd0);
        end else begin
          w_state_nxt = StRdIssue;
          w_idx_nxt   = r_idx + 16'd1;
        end
      end
      StFinish: w_state_nxt = StIdle;
      StError:  w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase

    // ERROR is only reachable from a wait state, so this fires on entry only.
    if (w_state_nxt == StError) begin
      w_timeout_nxt = 1'b1;
      w_done_nxt    = 1'b1;
      w_pass_nxt    = 1'b0;
    end

    w_wait_nxt  = (w_state_nxt != r_state) ? '0 : w_wait_inc;
    w_wstrb_nxt = (w_state_nxt == StWrIssue);
    w_rstrb_nxt = (w_state_nxt == StRdIssue);
    if (w_state_nxt == StWrIssue) w_wdata_nxt = f_pattern(w_idx_nxt);
  end

  assign bus.write_strb      = r_wstrb;
  assign bus.read_strb       = r_rstrb;
  assign bus.address         = {6'd0, r_idx};
  assign bus.data_write      = r_wdata;
  assign bus.step            = r_state;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.timeout         = r_timeout;
  assign bus.err_count       = r_err;
  assign bus.first_fail_addr = {6'd0, r_ffa};

endmodule

// File: tb/tb_psram_test_sequencer.sv
// Bench for psram_test_sequencer: three instances (4, 300 and 1 words) share a
// negedge controller model; strobes are scored against queued expectations.
module tb_psram_test_sequencer;

  typedef struct {
    int          inst;
    logic [21:0] addr;
    logic [15:0] data;
  } xact_t;

  typedef struct {
    string name;
    int inst, nwords, corr_addr, corr_all, hold;
    int e_done, e_pass, e_to, e_err, e_ffa, e_wait, e_fin, e_errst;
  } scn_t;

  localparam int Lat = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psram_test_sequencer_if bus0();
  psram_test_sequencer_if bus1();
  psram_test_sequencer_if bus2();

  psram_test_sequencer #(.NUM_WORDS(4), .SEED(16'hA5A5), .TIMEOUT(15)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.master));
  psram_test_sequencer #(.NUM_WORDS(300), .SEED(16'hA5A5), .TIMEOUT(15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master));
  psram_test_sequencer #(.NUM_WORDS(1), .SEED(16'hA5A5), .TIMEOUT(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master));

  logic        st[3];
  logic        rdy[3];
  logic [15:0] rdata[3];
  logic        wstb[3], rstb[3], dn[3], ps[3], to[3];
  logic [21:0] adr[3], ffa[3];
  logic [15:0] dw[3];
  logic [3:0]  stp[3];
  logic [7:0]  ec[3];

  assign bus0.start = st[0];  assign bus0.mem_ready = rdy[0];  assign bus0.data_read = rdata[0];
  assign bus1.start = st[1];  assign bus1.mem_ready = rdy[1];  assign bus1.data_read = rdata[1];
  assign bus2.start = st[2];  assign bus2.mem_ready = rdy[2];  assign bus2.data_read = rdata[2];

  assign wstb[0] = bus0.write_strb;  assign rstb[0] = bus0.read_strb;  assign adr[0] = bus0.address;
  assign dw[0]   = bus0.data_write;  assign stp[0]  = bus0.step;       assign dn[0]  = bus0.done;
  assign ps[0]   = bus0.pass;        assign to[0]   = bus0.timeout;    assign ec[0]  = bus0.err_count;
  assign ffa[0]  = bus0.first_fail_addr;
  assign wstb[1] = bus1.write_strb;  assign rstb[1] = bus1.read_strb;  assign adr[1] = bus1.address;
  assign dw[1]   = bus1.data_write;  assign stp[1]  = bus1.step;       assign dn[1]  = bus1.done;
  assign ps[1]   = bus1.pass;        assign to[1]   = bus1.timeout;    assign ec[1]  = bus1.err_count;
  assign ffa[1]  = bus1.first_fail_addr;
  assign wstb[2] = bus2.write_strb;  assign rstb[2] = bus2.read_strb;  assign adr[2] = bus2.address;
  assign dw[2]   = bus2.data_write;  assign stp[2]  = bus2.step;       assign dn[2]  = bus2.done;
  assign ps[2]   = bus2.pass;        assign to[2]   = bus2.timeout;    assign ec[2]  = bus2.err_count;
  assign ffa[2]  = bus2.first_fail_addr;

  int n_chk = 0;
  int n_err = 0;

  xact_t       wq[$];
  xact_t       rq[$];
  bit          hold[3] = '{1'b1, 1'b1, 1'b1};
  int          corr_addr[3] = '{-1, -1, -1};
  bit          corr_all[3] = '{1'b0, 1'b0, 1'b0};
  int          bcnt[3] = '{0, 0, 0};
  bit          pend_rd[3];
  int          pend_addr[3];
  logic [15:0] mem[3][512];
  logic [15:0] vec[4];
  scn_t        scn[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic logic [15:0] pattern(input logic [15:0] idx);
    return {idx[7:0], ~idx[7:0]} ^ 16'hA5A5;
  endfunction

  // Controller model and strobe scoreboard, both on the falling edge.
  always @(negedge clk) begin
    xact_t e;
    for (int k = 0; k < 3; k++) begin
      if (wstb[k] || rstb[k]) begin
        chk("strobe_exclusive", 32'(wstb[k] && rstb[k]), 32'd0);
        if (wstb[k]) begin
          if (wq.size() == 0) fail_now("unexpected_write");
          else begin
            e = wq.pop_front();
            chk("wr_inst", 32'(k), 32'(e.inst));
            chk("wr_addr", 32'(adr[k]), 32'(e.addr));
            chk("wr_data", 32'(dw[k]), 32'(e.data));
          end
          mem[k][adr[k][8:0]] = dw[k];
        end
        if (rstb[k]) begin
          if (rq.size() == 0) fail_now("unexpected_read");
          else begin
            e = rq.pop_front();
            chk("rd_inst", 32'(k), 32'(e.inst));
            chk("rd_addr", 32'(adr[k]), 32'(e.addr));
          end
        end
      end
      if (hold[k]) begin
        rdy[k]  = 1'b0;
        bcnt[k] = 0;
      end else if (wstb[k] || rstb[k]) begin
        rdy[k]       = 1'b0;
        bcnt[k]      = Lat;
        pend_rd[k]   = rstb[k];
        pend_addr[k] = int'(adr[k][8:0]);
      end else if (bcnt[k] > 0) begin
        bcnt[k]--;
        if (bcnt[k] == 0) begin
          rdy[k] = 1'b1;
          if (pend_rd[k])
            rdata[k] = mem[k][pend_addr[k]] ^
                       ((corr_all[k] || pend_addr[k] == corr_addr[k]) ? 16'h0001 : 16'h0000);
        end
      end else begin
        rdy[k] = 1'b1;
      end
    end
  end

  task automatic check_idle(input int k, input string tag);
    chk({tag, "_step"},  32'(stp[k]), 32'd0);
    chk({tag, "_wstrb"}, 32'(wstb[k]), 32'd0);
    chk({tag, "_rstrb"}, 32'(rstb[k]), 32'd0);
    chk({tag, "_addr"},  32'(adr[k]), 32'd0);
    chk({tag, "_wdata"}, 32'(dw[k]), 32'd0);
    chk({tag, "_done"},  32'(dn[k]), 32'd0);
    chk({tag, "_pass"},  32'(ps[k]), 32'd0);
    chk({tag, "_tout"},  32'(to[k]), 32'd0);
    chk({tag, "_errc"},  32'(ec[k]), 32'd0);
    chk({tag, "_ffa"},   32'(ffa[k]), 32'd0);
  endtask

  task automatic push_expect(input int i);
    xact_t x;
    x.inst = scn[i].inst;
    for (int a = 0; a < scn[i].nwords; a++) begin
      x.addr = 22'(a);
      x.data = (scn[i].inst == 0) ? vec[a] : pattern(16'(a));
      wq.push_back(x);
    end
    for (int a = 0; a < scn[i].nwords; a++) begin
      x.addr = 22'(a);
      x.data = '0;
      rq.push_back(x);
    end
  endtask

  task automatic run_scn(input int i);
    int k, n_wait, n_fin, n_errst;
    bit ended;
    k = scn[i].inst;
    corr_addr[k] = scn[i].corr_addr;
    corr_all[k]  = (scn[i].corr_all != 0);
    hold[k]      = (scn[i].hold != 0);
    if (scn[i].hold == 0) push_expect(i);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
    n_wait = 0; n_fin = 0; n_errst = 0; ended = 0;
    for (int c = 0; c < 20000 && !ended; c++) begin
      if (stp[k] == 4'd1)  n_wait++;
      if (stp[k] == 4'd9)  n_fin++;
      if (stp[k] == 4'd10) n_errst++;
      if (stp[k] == 4'd0 && dn[k]) ended = 1;
      else @(negedge clk);
    end
    if (!ended) fail_now({scn[i].name, "_no_done"});
    chk({scn[i].name, "_done"}, 32'(dn[k]), 32'(scn[i].e_done));
    chk({scn[i].name, "_pass"}, 32'(ps[k]), 32'(scn[i].e_pass));
    chk({scn[i].name, "_tout"}, 32'(to[k]), 32'(scn[i].e_to));
    chk({scn[i].name, "_errc"}, 32'(ec[k]), 32'(scn[i].e_err));
    chk({scn[i].name, "_ffa"},  32'(ffa[k]), 32'(scn[i].e_ffa));
    chk({scn[i].name, "_finish_cycles"}, 32'(n_fin), 32'(scn[i].e_fin));
    chk({scn[i].name, "_error_cycles"}, 32'(n_errst), 32'(scn[i].e_errst));
    if (scn[i].e_wait >= 0) chk({scn[i].name, "_wait_cycles"}, 32'(n_wait), 32'(scn[i].e_wait));
    chk({scn[i].name, "_writes_left"}, 32'(wq.size()), 32'd0);
    chk({scn[i].name, "_reads_left"}, 32'(rq.size()), 32'd0);
    hold[k] = 1'b0;
    corr_addr[k] = -1;
    corr_all[k] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    bit hit;
    vec = '{16'hA55A, 16'hA45B, 16'hA758, 16'hA659};
    //          name        inst nw  corr cAll hold done pass to err ffa wait fin errst
    scn[0] = '{"normal",    0,   4,  -1,  0,   0,   1,   1,   0, 0,  0,  -1,  1,  0};
    scn[1] = '{"corrupt1",  0,   4,  1,   0,   0,   1,   0,   0, 1,  1,  -1,  1,  0};
    scn[2] = '{"hold_low",  0,   4,  -1,  0,   1,   1,   0,   1, 0,  0,  15,  0,  1};
    scn[3] = '{"saturate",  1,   300, -1, 1,   0,   1,   0,   0, 255, 0, -1,  1,  0};
    scn[4] = '{"single",    2,   1,  -1,  0,   0,   1,   1,   0, 0,  0,  -1,  1,  0};
    scn[5] = '{"rerun",     0,   4,  -1,  0,   0,   1,   1,   0, 0,  0,  -1,  1,  0};
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      rdata[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_idle(k, "reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) hold[k] = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) run_scn(i);

    // Reset in the middle of a read handshake, then a clean rerun.
    push_expect(0);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (stp[0] == 4'd6) hit = 1;
      else @(negedge clk);
    end
    if (!hit) fail_now("reach_rd_ack");
    rst_n = 1'b0;
    @(negedge clk);
    check_idle(0, "midrun_reset");
    rst_n = 1'b1;
    wq.delete();
    rq.delete();
    repeat (6) @(negedge clk);
    run_scn(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/psram_test_sequencer.md
PSRAM_TEST_SEQUENCER -- requirements
Module: psram_test_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256, meaning word count tested per run (1..65536).
REQ-002 SHALL have parameter SEED, default 16'hA5A5, meaning XOR mask applied to the generated data pattern.
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning the maximum cycles spent waiting on any single mem_ready edge.
REQ-004 SHALL have port clk  input  1  system clock, the same clock as the memory controller.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-006 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-007 SHALL have port mem_ready  input  1  memory controller idle/ready; low while initializing or busy.
REQ-008 SHALL have port data_read  input  16  controller read data, valid while mem_ready=1 after a read.
REQ-009 SHALL have port write_strb  output  1  one-cycle write command pulse.
REQ-010 SHALL have port read_strb  output  1  one-cycle read command pulse.
REQ-011 SHALL have port address  output  22  word address, equal to the current index zero-extended.
REQ-012 SHALL have port data_write  output  16  write data, held stable from strobe until the command completes.
REQ-013 SHALL have port step  output  4  current state encoding, for the on-chip analyzer.
REQ-014 SHALL have ports done, pass, timeout  output  1 each  sticky run status.
REQ-015 SHALL have port err_count  output  8  saturating mismatch count.
REQ-016 SHALL have port first_fail_addr  output  22  address of the first mismatch.

Function
REQ-017 SHALL define data_write as ({idx[7:0], ~idx[7:0]} ^ SEED), where idx is the 16-bit word index; the expected read value SHALL use the same formula.
REQ-018 SHALL implement these states, with step equal to the encoding: IDLE=0, WAIT_INIT=1, WR_ISSUE=2, WR_ACK=3, WR_DONE=4, RD_ISSUE=5, RD_ACK=6, RD_DONE=7, CHECK=8, FINISH=9, ERROR=10.
REQ-019 SHALL, in IDLE, go to WAIT_INIT on start=1, clearing done, pass, timeout, err_count, first_fail_addr and idx in the same cycle; start SHALL be ignored in every other state.
REQ-020 SHALL, in WAIT_INIT, go to WR_ISSUE when mem_ready=1.
REQ-021 SHALL, in WR_ISSUE, assert write_strb for exactly one cycle with address/data_write valid in that cycle, then go to WR_ACK.
REQ-022 SHALL, in WR_ACK, wait for mem_ready=0 and then go to WR_DONE; in WR_DONE, wait for mem_ready=1.
REQ-023 SHALL, on leaving WR_DONE, go to RD_ISSUE with idx reset to 0 if idx=NUM_WORDS-1; otherwise it SHALL increment idx and go to WR_ISSUE.
REQ-024 SHALL handle the read phase the same way: RD_ISSUE pulses read_strb, RD_ACK waits for mem_ready=0, RD_DONE waits for mem_ready=1 and registers data_read in that cycle, then goes to CHECK.
REQ-025 SHALL, in CHECK, compare the registered data against the expected value; on mismatch it SHALL increment err_count, saturating at 255, and capture first_fail_addr only if err_count was 0.
REQ-026 SHALL, on leaving CHECK, go to FINISH if idx=NUM_WORDS-1; otherwise it SHALL increment idx and go to RD_ISSUE.
REQ-027 SHALL, in FINISH, set done=1 and pass=(err_count==0), then return to IDLE next cycle; done and pass SHALL hold until the next start.
REQ-028 SHALL keep a wait counter that clears on entry to WAIT_INIT, WR_ACK, WR_DONE, RD_ACK and RD_DONE and increments every cycle spent in those states.
REQ-029 SHALL, when the wait counter reaches TIMEOUT, go to ERROR, setting timeout=1, done=1 and pass=0; ERROR SHALL return to IDLE next cycle.
REQ-030 SHALL make read_strb and write_strb registered outputs that are never high together and never high outside their ISSUE states.
REQ-031 SHALL satisfy the boundary case NUM_WORDS=1: one write and one read, with idx staying 0.
REQ-032 SHALL, if mem_ready is already 0 in the cycle after a strobe, complete the ACK wait in one cycle.

Reset
REQ-033 SHALL, on rst_n=0 at a clk edge, enter IDLE and clear every output and idx to 0 (including the strobes, step=0, done=0, pass=0), even mid-run; the controller's in-flight command is abandoned.

Verification
REQ-034 SHALL pass this scenario: NUM_WORDS=4, SEED=16'hA5A5, ideal controller model; start -> four write_strb pulses on addresses 0..3 (addr 2 carries data 16'hA758), then four read_strb pulses, then done=1, pass=1, err_count=0, step=9 for one cycle.
REQ-035 SHALL pass this scenario: the model corrupts the read at addr 1 -> err_count=1, first_fail_addr=1, pass=0, done=1.
REQ-036 SHALL pass this scenario: mem_ready held at 0 after start with TIMEOUT=15 -> ERROR after 15 cycles in WAIT_INIT, timeout=1, pass=0, no strobe ever issued.
REQ-037 SHALL pass this scenario: rst_n=0 asserted during RD_ACK -> the next cycle shows step=0 and all outputs 0; a fresh start then runs to pass=1.
REQ-038 SHALL pass this scenario: every read corrupted with NUM_WORDS=300 -> err_count saturates at 255 and first_fail_addr=0.
REQ-039 SHALL pass this scenario: NUM_WORDS=1 -> exactly one write_strb and one read_strb, then pass=1.
